aes_stream_packer: RTL and testbench

Upstream stage of the AES HWPE engine. Takes the 32-bit plaintext stream from the HWPE streamer source and packs every four accepted words into one 128-bit AES state block. It then presents that block to the AES core over a valid/ready handshake. The block count per job comes from the register file; the packer raises a done pulse for the controller when the last block has been taken.

---
 rtl/aes_stream_packer.sv | 175 +++++++++++++++++
 tb/tb_aes_stream_packer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_stream_packer.sv
// Packs four 32-bit stream words into one 128-bit AES state block and offers it over valid/ready.
// Optional macro AES_PACKER_BYTE_SWAP_EN reverses each word's bytes (and strobes) before packing.
module aes_stream_packer #(
    parameter int unsigned NB_W = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            clear,
    input  logic            enable,
    input  logic            start,
    input  logic [NB_W-1:0] nblocks_i,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_data,
    input  logic [3:0]      in_strb,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [127:0]    out_data,
    output logic            busy_o,
    output logic            done_o,
    output logic [NB_W-1:0] blk_cnt_o
);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        HOLD,
        DONE
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      word_idx_q, word_idx_d;
    logic [NB_W-1:0] blk_cnt_q, blk_cnt_d;
    logic [NB_W-1:0] nblocks_q, nblocks_d;
    logic [127:0]    data_q, data_d;

    logic            in_fire;
    logic            out_fire;
    logic            job_start;
    logic            last_block;
    logic [NB_W-1:0] blk_cnt_inc;
    logic [31:0]     word_masked;
    logic [31:0]     word_packed;

    assign in_fire     = in_valid & in_ready;
    assign out_fire    = out_valid & out_ready;
    assign job_start   = (state_q == IDLE) & start & enable;
    assign blk_cnt_inc = blk_cnt_q + NB_W'(1);
    assign last_block  = (blk_cnt_inc == nblocks_q);

    assign word_masked = in_data & {{8{in_strb[3]}}, {8{in_strb[2]}},
                                    {8{in_strb[1]}}, {8{in_strb[0]}}};

`ifdef AES_PACKER_BYTE_SWAP_EN
    assign word_packed = {word_masked[7:0], word_masked[15:8],
                          word_masked[23:16], word_masked[31:24]};
`else
    assign word_packed = word_masked;
`endif

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else if (clear) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; HOLD handshakes and the DONE pulse proceed even while frozen
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (job_start) begin
                    state_d = (nblocks_i == '0) ? DONE : FILL;
                end
            end
            FILL: begin
                if (in_fire && (word_idx_q == 2'd3)) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_fire) begin
                    state_d = last_block ? DONE : FILL;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy_o    = 1'b0;
        done_o    = 1'b0;
        case (state_q)
            FILL: begin
                in_ready = enable;
                busy_o   = 1'b1;
            end
            HOLD: begin
                out_valid = 1'b1;
                busy_o    = 1'b1;
            end
            DONE:    done_o = 1'b1;
            default: ;
        endcase
    end

    // Datapath next-state
    always_comb begin
        word_idx_d = word_idx_q;
        blk_cnt_d  = blk_cnt_q;
        nblocks_d  = nblocks_q;
        data_d     = data_q;
        case (state_q)
            IDLE: begin
                if (job_start) begin
                    nblocks_d  = nblocks_i;
                    blk_cnt_d  = '0;
                    word_idx_d = '0;
                end
            end
            FILL: begin
                if (in_fire) begin
                    case (word_idx_q)
                        2'd0:    data_d[127:96] = word_packed;
                        2'd1:    data_d[95:64]  = word_packed;
                        2'd2:    data_d[63:32]  = word_packed;
                        default: data_d[31:0]   = word_packed;
                    endcase
                    word_idx_d = word_idx_q + 2'd1;
                end
            end
            HOLD: begin
                if (out_fire) begin
                    blk_cnt_d = blk_cnt_inc;
                    if (!last_block) begin
                        data_d = '0;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            word_idx_q <= '0;
            blk_cnt_q  <= '0;
            nblocks_q  <= '0;
            data_q     <= '0;
        end else if (clear) begin
            word_idx_q <= '0;
            blk_cnt_q  <= '0;
            nblocks_q  <= '0;
            data_q     <= '0;
        end else begin
            word_idx_q <= word_idx_d;
            blk_cnt_q  <= blk_cnt_d;
            nblocks_q  <= nblocks_d;
            data_q     <= data_d;
        end
    end

    assign out_data  = data_q;
    assign blk_cnt_o = blk_cnt_q;

endmodule

// File: tb/tb_aes_stream_packer.sv
// Bench for aes_stream_packer: fixed vector table, hand-written corner sequences and
// randomized jobs checked against a word-counting block model.
module tb_aes_stream_packer;

    localparam int unsigned NB_W = 16;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            clear;
    logic            enable;
    logic            start;
    logic [NB_W-1:0] nblocks_i;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_data;
    logic [3:0]      in_strb;
    logic            out_valid;
    logic            out_ready;
    logic [127:0]    out_data;
    logic            busy_o;
    logic            done_o;
    logic [NB_W-1:0] blk_cnt_o;

    int unsigned n_chk = 0;
    int unsigned n_fail = 0;

    aes_stream_packer #(.NB_W(NB_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (clear),
        .enable    (enable),
        .start     (start),
        .nblocks_i (nblocks_i),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_strb   (in_strb),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .blk_cnt_o (blk_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0][31:0] w;
        logic [3:0][3:0]  s;
        logic [127:0]     exp_plain;
        logic [127:0]     exp_swap;
    } vec_t;

    vec_t vecs [3];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Byte masking and optional byte reversal, straight from the packing rule
    function automatic logic [31:0] pack_word(input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[8*b +: 8] = s[b] ? d[8*b +: 8] : 8'h00;
        end
`ifdef AES_PACKER_BYTE_SWAP_EN
        r = {r[7:0], r[15:8], r[23:16], r[31:24]};
`endif
        return r;
    endfunction

    task automatic set_vec(input int i,
                           input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2, input logic [31:0] w3,
                           input logic [3:0] s0, input logic [3:0] s1,
                           input logic [3:0] s2, input logic [3:0] s3,
                           input logic [127:0] ep, input logic [127:0] es);
        vecs[i].w[0] = w0; vecs[i].w[1] = w1; vecs[i].w[2] = w2; vecs[i].w[3] = w3;
        vecs[i].s[0] = s0; vecs[i].s[1] = s1; vecs[i].s[2] = s2; vecs[i].s[3] = s3;
        vecs[i].exp_plain = ep;
        vecs[i].exp_swap  = es;
    endtask

    // One job driven cycle by cycle; the model tracks words per block and blocks per job
    task automatic run_job(input int unsigned nblk, input int unsigned stall_blk,
                           input int unsigned stall_len, input bit rnd);
        logic [127:0] cur;
        int unsigned  words, blocks, stall_ctr, cyc;
        bit           active, done_exp;
        enable    = 1'b1;
        start     = 1'b1;
        nblocks_i = nblk[NB_W-1:0];
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        start     = 1'b0;
        nblocks_i = NB_W'($urandom);
        active = 1'b1; done_exp = 1'b0;
        words = 0; blocks = 0; stall_ctr = 0; cyc = 0; cur = '0;
        while (active || done_exp || cyc == 0 || busy_o) begin
            chk("job_in_ready", in_ready, active && words < 4 && enable);
            chk("job_out_valid", out_valid, active && words == 4);
            if (active && words == 4) chk("job_out_data", out_data, cur);
            chk("job_busy", busy_o, active);
            chk("job_done", done_o, done_exp);
            chk("job_blk_cnt", blk_cnt_o, blocks[NB_W-1:0]);
            if (!active && !done_exp) break;
            cyc++;
            if (cyc > 4000) begin
                n_fail++;
                $display("FAIL job_timeout: got %0d cycles expected at most 4000", cyc);
                break;
            end
            if (rnd) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                enable    = ($urandom_range(0, 4) != 0);
                out_ready = $urandom_range(0, 1);
                start     = active && ($urandom_range(0, 7) == 0);
                nblocks_i = NB_W'($urandom);
                in_strb   = 4'($urandom);
            end else begin
                in_valid  = 1'b1;
                enable    = 1'b1;
                out_ready = !(blocks == stall_blk && words == 4 && stall_ctr < stall_len);
                in_strb   = 4'hF;
            end
            in_data = $urandom;
            if (!rnd && blocks == stall_blk && words == 4 && !out_ready) stall_ctr++;
            if (done_exp) done_exp = 1'b0;
            if (active && words < 4 && enable && in_valid) begin
                cur = {cur[95:0], pack_word(in_data, in_strb)};
                words++;
            end else if (active && words == 4 && out_ready) begin
                blocks++;
                words = 0;
                cur = '0;
                if (blocks == nblk) begin
                    active   = 1'b0;
                    done_exp = 1'b1;
                end
            end
            @(negedge clk);
        end
        start    = 1'b0;
        in_valid = 1'b0;
        enable   = 1'b1;
        if (!rnd) chk("stall_len", stall_ctr, (stall_blk < nblk) ? stall_len : 0);
    endtask

    initial begin
        logic [31:0] fw [4];
        reset_n = 1'b0; clear = 1'b0; enable = 1'b1; start = 1'b0; nblocks_i = '0;
        in_valid = 1'b0; in_data = '0; in_strb = '0; out_ready = 1'b0;

        set_vec(0, 32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF,
                4'hF, 4'hF, 4'hF, 4'hF,
                128'h00112233_44556677_8899AABB_CCDDEEFF,
                128'h33221100_77665544_BBAA9988_FFEEDDCC);
        set_vec(1, 32'hDEADBEEF, 32'h12345678, 32'hCAFEF00D, 32'hA5A5A5A5,
                4'b0101, 4'b1010, 4'b0000, 4'b1111,
                128'h00AD00EF_12005600_00000000_A5A5A5A5,
                128'hEF00AD00_00560012_00000000_A5A5A5A5);
        set_vec(2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                4'b0001, 4'b0010, 4'b0100, 4'b1000,
                128'h000000FF_0000FF00_00FF0000_FF000000,
                128'hFF000000_00FF0000_0000FF00_000000FF);

        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_done", done_o, 1'b0);
        chk("rst_out_data", out_data, '0);
        chk("rst_blk_cnt", blk_cnt_o, '0);
        reset_n = 1'b1;
        @(negedge clk);

        // Single-block vectors from the table
        for (int i = 0; i < 3; i++) begin
            start = 1'b1; nblocks_i = 16'd1; enable = 1'b1; out_ready = 1'b1;
            @(negedge clk);
            start = 1'b0;
            chk("tbl_busy", busy_o, 1'b1);
            chk("tbl_in_ready", in_ready, 1'b1);
            for (int w = 0; w < 4; w++) begin
                in_valid = 1'b1; in_data = vecs[i].w[w]; in_strb = vecs[i].s[w];
                @(negedge clk);
            end
            in_valid = 1'b0;
            chk("tbl_out_valid", out_valid, 1'b1);
            chk("tbl_hold_in_ready", in_ready, 1'b0);
`ifdef AES_PACKER_BYTE_SWAP_EN
            chk("tbl_out_data", out_data, vecs[i].exp_swap);
`else
            chk("tbl_out_data", out_data, vecs[i].exp_plain);
`endif
            @(negedge clk);
            chk("tbl_done", done_o, 1'b1);
            chk("tbl_blk_cnt", blk_cnt_o, 16'd1);
            chk("tbl_out_valid_off", out_valid, 1'b0);
            @(negedge clk);
            chk("tbl_done_off", done_o, 1'b0);
            chk("tbl_idle", busy_o, 1'b0);
        end

        // Empty job
        start = 1'b1; nblocks_i = '0;
        @(negedge clk);
        start = 1'b0;
        chk("empty_done", done_o, 1'b1);
        chk("empty_in_ready", in_ready, 1'b0);
        chk("empty_busy", busy_o, 1'b0);
        @(negedge clk);
        chk("empty_done_off", done_o, 1'b0);
        chk("empty_in_ready2", in_ready, 1'b0);

        // Freeze after two words
        fw[0] = 32'h0BADF00D; fw[1] = 32'h13579BDF; fw[2] = 32'h2468ACE0; fw[3] = 32'hFEEDFACE;
        start = 1'b1; nblocks_i = 16'd1; out_ready = 1'b1; in_strb = 4'hF;
        @(negedge clk);
        start = 1'b0;
        for (int w = 0; w < 2; w++) begin
            in_valid = 1'b1; in_data = fw[w];
            @(negedge clk);
        end
        enable = 1'b0; in_data = 32'h77777777;
        for (int k = 0; k < 3; k++) begin
            #1 chk("frz_in_ready", in_ready, 1'b0);
            @(negedge clk);
        end
        enable = 1'b1;
        for (int w = 2; w < 4; w++) begin
            in_data = fw[w];
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("frz_out_valid", out_valid, 1'b1);
        chk("frz_out_data", out_data, {pack_word(fw[0], 4'hF), pack_word(fw[1], 4'hF),
                                       pack_word(fw[2], 4'hF), pack_word(fw[3], 4'hF)});
        @(negedge clk);
        chk("frz_done", done_o, 1'b1);
        @(negedge clk);

        // Clear while holding a block
        start = 1'b1; nblocks_i = 16'd2; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int w = 0; w < 4; w++) begin
            in_valid = 1'b1; in_data = 32'h5A5A0000 | 32'(w + 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("clr_pre_valid", out_valid, 1'b1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clr_out_valid", out_valid, 1'b0);
        chk("clr_out_data", out_data, '0);
        chk("clr_busy", busy_o, 1'b0);
        chk("clr_blk_cnt", blk_cnt_o, '0);
        run_job(1, 99, 0, 1'b0);

        // Backpressure on block 1 of a three-block job
        run_job(3, 1, 7, 1'b0);

        // Randomized jobs
        for (int j = 0; j < 8; j++) begin
            run_job($urandom_range(1, 4), 99, 0, 1'b1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
